// File: rtl/bcd_digit_converter.sv
// bcd_digit_converter: sequential double-dabble binary-to-packed-BCD converter with saturation on overflow
module bcd_digit_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);
  localparam int CW = $clog2(BIN_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);
  localparam logic [39:0] MAX_VAL = 40'(10 ** DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state;
  logic [BIN_WIDTH-1:0] sh;
  logic [4*DIGITS-1:0] acc, adj, acc_nx;
  logic [CW-1:0] cnt;
  logic ovf_pend;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
  end
  assign acc_nx = {adj[4*DIGITS-2:0], sh[BIN_WIDTH-1]};
  // conversion FSM: capture, BIN_WIDTH shift-add-3 steps, then publish saturated result
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      ovf_pend <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      digits <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh <= bin;
          acc <= '0;
          cnt <= '0;
          ovf_pend <= 40'(bin) > MAX_VAL;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sh <= {sh[BIN_WIDTH-2:0], 1'b0};
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIN;
            done <= 1'b1;
            digits <= ovf_pend ? {DIGITS{4'h9}} : acc_nx;
            overflow <= ovf_pend;
          end
        end
        FIN: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_digit_converter.sv
// tb_bcd_digit_converter: randomized scoreboard bench against a decimal-arithmetic reference model
module tb_bcd_digit_converter;
  localparam int BW = 14;
  localparam int ND = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [BW-1:0] bin = '0;
  logic busy, done, overflow;
  logic [4*ND-1:0] digits;
  int cyc = 0;
  int total = 0, bad = 0;
  typedef struct {logic [15:0] d; logic o; int e0;} exp_t;
  exp_t q[$];

  bcd_digit_converter #(.BIN_WIDTH(BW), .DIGITS(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .digits(digits), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(int v, int e0);
    exp_t r;
    r.o = v > 10 ** ND - 1;
    r.d = 16'h9999;
    r.e0 = e0;
    if (!r.o) begin
      r.d = '0;
      for (int i = 0; i < ND; i++) r.d[4*i+:4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("digits", 32'(digits), 32'(e.d));
        check("overflow", 32'(overflow), 32'(e.o));
        check("latency", cyc, e.e0 + BW);
        check("busy_in_done", 32'(busy), 1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 32'(n < 200), 1);
  endtask

  task automatic conv(int v);
    wait_idle();
    @(posedge clk);
    #1;
    bin = BW'(v);
    start = 1'b1;
    q.push_back(model(v, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    bin = BW'($urandom);
  endtask

  initial begin
    int e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_digits", 32'(digits), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    conv(1234);
    conv(0);
    conv(9999);
    conv(10);
    conv(12000);
    conv(42);
    conv(10000);
    conv(16383);
    wait_idle();
    @(posedge clk);
    #1;
    bin = 14'd555;
    start = 1'b1;
    q.push_back(model(555, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bin = 14'd777;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    bin = 14'd2468;
    start = 1'b1;
    e = cyc + 1;
    q.push_back(model(2468, e));
    q.push_back(model(2468, e + BW + 2));
    repeat (BW + 3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    bin = 14'd8888;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_digits", 32'(digits), 0);
    check("abort_overflow", 32'(overflow), 0);
    repeat (20) @(posedge clk);
    #1;
    conv(321);
    repeat (30) begin
      conv(int'($urandom_range(0, 16383)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
